// File: rtl/serial_vector_collector_if.sv
// Handshake bundle between a serial bit source / word consumer and the collector.
// Optional parity_err member exists only when PARITY_EN is defined.
interface serial_vector_collector_if #(
   parameter int unsigned WIDTH = 8
);
   logic             ser_in;
   logic             ser_valid;
   logic             ser_ready;
   logic             clear;
   logic [WIDTH-1:0] out_vector;
   logic             out_valid;
   logic             out_ready;
   logic [4:0]       bit_count;
`ifdef PARITY_EN
   logic             parity_err;
`endif

   // Collector side
   modport slave (
      input  ser_in,
      input  ser_valid,
      input  clear,
      input  out_ready,
      output ser_ready,
      output out_vector,
      output out_valid,
`ifdef PARITY_EN
      output parity_err,
`endif
      output bit_count
   );

   // Bit source and word consumer side
   modport master (
      output ser_in,
      output ser_valid,
      output clear,
      output out_ready,
      input  ser_ready,
      input  out_vector,
      input  out_valid,
`ifdef PARITY_EN
      input  parity_err,
`endif
      input  bit_count
   );
endinterface

// File: rtl/serial_vector_collector.sv
// Serial-to-parallel collector: MSB-first bit assembly feeding a one-entry holding register.
// Define PARITY_EN to append an even-parity bit to each frame and report parity_err.
module serial_vector_collector #(
   parameter int unsigned WIDTH = 8
) (
   input logic                     clk,
   input logic                     rst_n,
   serial_vector_collector_if.slave svc_if
);

`ifdef PARITY_EN
   localparam int unsigned FRAME = WIDTH + 1;
`else
   localparam int unsigned FRAME = WIDTH;
`endif
   localparam int unsigned CNT_W = (FRAME > 32) ? 6 : 5;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [WIDTH-1:0] vec_q, vec_d;
   logic [WIDTH-1:0] word;
   logic             last_bit;
   logic             ser_ready;
   logic             accept;
   logic             word_done;
`ifdef PARITY_EN
   logic             perr_q, perr_d;
   logic             perr_calc;
`endif

   // Stall only the word-completing bit, and only while the held word cannot drain
   assign last_bit  = (cnt_q == CNT_W'(FRAME - 1));
   assign ser_ready = !(last_bit && (state_q == ST_FULL) && !svc_if.out_ready);
   assign accept    = svc_if.ser_valid && ser_ready;
   assign word_done = accept && last_bit && !svc_if.clear;

`ifdef PARITY_EN
   // Parity bit is the frame tail; data bits are already in the shift register
   assign word      = shift_q;
   assign perr_calc = (^shift_q) ^ svc_if.ser_in;
`else
   assign word      = {shift_q[WIDTH-2:0], svc_if.ser_in};
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_EMPTY;
         cnt_q   <= '0;
         shift_q <= '0;
         vec_q   <= '0;
`ifdef PARITY_EN
         perr_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         vec_q   <= vec_d;
`ifdef PARITY_EN
         perr_q  <= perr_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      vec_d   = vec_q;
`ifdef PARITY_EN
      perr_d  = perr_q;
`endif

      // Bit collection; clear discards any bit offered alongside it
      if (svc_if.clear) begin
         cnt_d   = '0;
         shift_d = '0;
      end else if (accept) begin
         cnt_d = last_bit ? '0 : cnt_q + CNT_W'(1);
         if (cnt_q < CNT_W'(WIDTH)) begin
            shift_d = {shift_q[WIDTH-2:0], svc_if.ser_in};
         end
      end

      case (state_q)
         ST_EMPTY: begin
            if (word_done) begin
               state_d = ST_FULL;
            end
         end
         ST_FULL: begin
            if (!word_done && svc_if.out_ready) begin
               state_d = ST_EMPTY;
`ifdef PARITY_EN
               perr_d  = 1'b0;
`endif
            end
         end
         default: state_d = ST_EMPTY;
      endcase

      // A completing word loads the holding register, replacing a draining one
      if (word_done) begin
         vec_d  = word;
`ifdef PARITY_EN
         perr_d = perr_calc;
`endif
      end
   end

   assign svc_if.ser_ready  = ser_ready;
   assign svc_if.out_vector = vec_q;
   assign svc_if.out_valid  = (state_q == ST_FULL);
   assign svc_if.bit_count  = 5'(cnt_q);
`ifdef PARITY_EN
   assign svc_if.parity_err = perr_q;
`endif

endmodule

// File: tb/tb_serial_vector_collector.sv
// Scoreboard bench for serial_vector_collector: expected words queued at send, checked on drain.
module tb_serial_vector_collector;

`ifdef PARITY_EN
   localparam int FRAME = 9;
`else
   localparam int FRAME = 8;
`endif

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;
   logic [8:0] exp_q[$];

   serial_vector_collector_if #(.WIDTH(8)) dut_if ();

   serial_vector_collector #(.WIDTH(8)) u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .svc_if (dut_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic frame_bit(input logic [7:0] d, input logic flip, input int idx);
      if (idx < 8) return d[7-idx];
      return (^d) ^ flip;
   endfunction

   function automatic logic obs_perr();
`ifdef PARITY_EN
      return dut_if.parity_err;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic exp_perr(input logic flip);
`ifdef PARITY_EN
      return flip;
`else
      return 1'b0;
`endif
   endfunction

   // Present one bit and hold it until the collector takes it
   task automatic send_bit(input logic b);
      int n;
      n = 0;
      dut_if.ser_in    = b;
      dut_if.ser_valid = 1'b1;
      @(negedge clk);
      while (!dut_if.ser_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("stall_timeout", 32'd1, 32'd0);
      @(posedge clk);
      #1;
      dut_if.ser_valid = 1'b0;
   endtask

   task automatic send_word(input logic [7:0] d, input logic flip);
      for (int i = 0; i < FRAME; i++) begin
         if (i == FRAME - 1) exp_q.push_back({exp_perr(flip), d});
         send_bit(frame_bit(d, flip, i));
      end
   endtask

   // Scoreboard: every word taken by the consumer must match the queue head
   always @(negedge clk) begin
      logic [8:0] e;
      if (rst_n && dut_if.out_valid && dut_if.out_ready) begin
         if (exp_q.size() == 0) begin
            chk("sb_unexpected", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("sb_word", {23'd0, obs_perr(), dut_if.out_vector}, {23'd0, e});
         end
      end
   end

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n            = 1'b0;
      dut_if.ser_in    = 1'b0;
      dut_if.ser_valid = 1'b0;
      dut_if.clear     = 1'b0;
      dut_if.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_valid", 32'(dut_if.out_valid), 32'd0);
      chk("rst_vector", 32'(dut_if.out_vector), 32'd0);
      chk("rst_count", 32'(dut_if.bit_count), 32'd0);
      chk("rst_ready", 32'(dut_if.ser_ready), 32'd1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Single word, consumer always ready: one-cycle out_valid
      dut_if.out_ready = 1'b1;
      send_word(8'h55, 1'b0);
      @(negedge clk);
      chk("t1_valid", 32'(dut_if.out_valid), 32'd1);
      chk("t1_vector", 32'(dut_if.out_vector), 32'h55);
      chk("t1_perr", 32'(obs_perr()), 32'd0);
      @(negedge clk);
      chk("t1_valid_drop", 32'(dut_if.out_valid), 32'd0);
      @(posedge clk);
      #1;

      // Stall on the completing bit while the held word is not taken
      dut_if.out_ready = 1'b0;
      send_word(8'hF0, 1'b0);
      @(negedge clk);
      chk("t2_valid", 32'(dut_if.out_valid), 32'd1);
      chk("t2_vector", 32'(dut_if.out_vector), 32'hF0);
      @(posedge clk);
      #1;
      for (int i = 0; i < FRAME - 1; i++) send_bit(frame_bit(8'h0F, 1'b0, i));
      exp_q.push_back({1'b0, 8'h0F});
      dut_if.ser_in    = frame_bit(8'h0F, 1'b0, FRAME - 1);
      dut_if.ser_valid = 1'b1;
      @(negedge clk);
      chk("t2_stall_ready", 32'(dut_if.ser_ready), 32'd0);
      chk("t2_stall_count", 32'(dut_if.bit_count), 32'(FRAME - 1));
      chk("t2_hold_vector", 32'(dut_if.out_vector), 32'hF0);
      @(posedge clk);
      #1;
      chk("t2_still_stalled", 32'(dut_if.ser_ready), 32'd0);
      dut_if.out_ready = 1'b1;
      @(negedge clk);
      chk("t2_release_ready", 32'(dut_if.ser_ready), 32'd1);
      @(posedge clk);
      #1;
      dut_if.ser_valid = 1'b0;
      @(negedge clk);
      chk("t2_new_valid", 32'(dut_if.out_valid), 32'd1);
      chk("t2_new_vector", 32'(dut_if.out_vector), 32'h0F);
      @(negedge clk);
      chk("t2_drained", 32'(dut_if.out_valid), 32'd0);
      @(posedge clk);
      #1;

      // Drain and refill on the same edge: no bubble
      dut_if.out_ready = 1'b0;
      send_word(8'h0F, 1'b0);
      for (int i = 0; i < FRAME - 1; i++) send_bit(frame_bit(8'hCC, 1'b0, i));
      exp_q.push_back({1'b0, 8'hCC});
      dut_if.ser_in    = frame_bit(8'hCC, 1'b0, FRAME - 1);
      dut_if.ser_valid = 1'b1;
      dut_if.out_ready = 1'b1;
      @(negedge clk);
      chk("t3_old_vector", 32'(dut_if.out_vector), 32'h0F);
      chk("t3_ready", 32'(dut_if.ser_ready), 32'd1);
      @(posedge clk);
      #1;
      dut_if.ser_valid = 1'b0;
      @(negedge clk);
      chk("t3_valid_kept", 32'(dut_if.out_valid), 32'd1);
      chk("t3_new_vector", 32'(dut_if.out_vector), 32'hCC);
      @(negedge clk);
      chk("t3_drained", 32'(dut_if.out_valid), 32'd0);
      @(posedge clk);
      #1;

      // Clear beats a simultaneous bit
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      dut_if.ser_in    = 1'b1;
      dut_if.ser_valid = 1'b1;
      dut_if.clear     = 1'b1;
      @(posedge clk);
      #1;
      dut_if.ser_valid = 1'b0;
      dut_if.clear     = 1'b0;
      @(negedge clk);
      chk("t4_count_cleared", 32'(dut_if.bit_count), 32'd0);
      chk("t4_no_word", 32'(dut_if.out_valid), 32'd0);
      @(posedge clk);
      #1;
      dut_if.out_ready = 1'b0;
      send_word(8'hCC, 1'b0);
      @(negedge clk);
      chk("t4_vector", 32'(dut_if.out_vector), 32'hCC);
      dut_if.out_ready = 1'b1;
      @(posedge clk);
      #1;

      // Asynchronous reset with a held word and a partial word
      dut_if.out_ready = 1'b0;
      send_word(8'hA5, 1'b0);
      for (int i = 0; i < 5; i++) send_bit(frame_bit(8'h3C, 1'b0, i));
      @(negedge clk);
      chk("t5_pre_count", 32'(dut_if.bit_count), 32'd5);
      chk("t5_pre_valid", 32'(dut_if.out_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_valid", 32'(dut_if.out_valid), 32'd0);
      chk("t5_vector", 32'(dut_if.out_vector), 32'd0);
      chk("t5_count", 32'(dut_if.bit_count), 32'd0);
      exp_q.delete();
      dut_if.out_ready = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Back-to-back words through the scoreboard
      send_word(8'h81, 1'b0);
      send_word(8'h7E, 1'b0);
      send_word(8'h3C, 1'b0);
      repeat (2) @(negedge clk);

`ifdef PARITY_EN
      // Parity: correct bit, then flipped bit
      dut_if.out_ready = 1'b0;
      send_word(8'h55, 1'b0);
      @(negedge clk);
      chk("t6_perr_good", 32'(dut_if.parity_err), 32'd0);
      chk("t6_vector", 32'(dut_if.out_vector), 32'h55);
      dut_if.out_ready = 1'b1;
      @(posedge clk);
      #1;
      dut_if.out_ready = 1'b0;
      send_word(8'h55, 1'b1);
      @(negedge clk);
      chk("t6_perr_bad", 32'(dut_if.parity_err), 32'd1);
      chk("t6_valid", 32'(dut_if.out_valid), 32'd1);
      dut_if.out_ready = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("t6_perr_cleared", 32'(dut_if.parity_err), 32'd0);
`endif

      repeat (2) @(negedge clk);
      chk("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
